// File: rtl/mod461_horner_reducer.sv
`default_nettype none
// ============================================================================
// Module   : mod461_horner_reducer
// Purpose  : Streams a base-64 operand MSB-first and returns it modulo 461,
//            with a valid/ready handshake on both digit and result sides.
//            Define MOD461_FRAMECHK_EN to enable 67-digit frame checking.
// Revision : 1.0 - initial release
// ============================================================================
module mod461_horner_reducer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] digit,
    input  logic       digit_valid,
    input  logic       digit_last,
    output logic       digit_ready,
    output logic [8:0] res,
    output logic       res_valid,
    output logic       res_err,
    input  logic       res_ready
);

    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_ACCUM     = 2'd1;
    localparam logic [1:0]  S_DONE      = 2'd2;
    localparam logic [14:0] C_MOD       = 15'd461;
    localparam logic [6:0]  C_FRAME_LEN = 7'd67;

    logic [1:0]  r_state;
    logic [8:0]  r_acc;
    logic [8:0]  r_res;
    logic        r_live;
    logic        w_take;
    logic        w_end;
    logic [8:0]  w_base;
    logic [14:0] w_wide;
    logic [14:0] w_red;
    logic [8:0]  w_acc_next;

    // r_live holds digit_ready low until the first edge after reset release.
    assign digit_ready = r_live && (r_state != S_DONE);
    assign res_valid   = (r_state == S_DONE);
    assign res         = r_res;
    assign w_take      = digit_valid && digit_ready;

    // A frame always starts from zero, so IDLE ignores any stale accumulator.
    assign w_base = (r_state == S_IDLE) ? 9'd0 : r_acc;
    assign w_wide = {w_base, digit};

    // acc*64+d < 461*64, so six conditional subtractions of 461<<k leave it in 0..460.
    always_comb begin
        w_red = w_wide;
        for (int k = 5; k >= 0; k--) begin
            if (w_red >= (C_MOD << k)) begin
                w_red = w_red - (C_MOD << k);
            end
        end
        w_acc_next = w_red[8:0];
    end

`ifdef MOD461_FRAMECHK_EN
    logic [6:0] r_cnt;
    logic [6:0] w_cnt_next;
    logic       w_err;
    logic       r_res_err;

    assign w_cnt_next = (r_state == S_IDLE) ? 7'd1 : (r_cnt + 7'd1);
    // The 67th digit closes the frame even without digit_last, flagged as an error.
    assign w_end      = digit_last || (w_cnt_next == C_FRAME_LEN);
    assign w_err      = (w_cnt_next != C_FRAME_LEN) || !digit_last;
    assign res_err    = r_res_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 7'd0;
            r_res_err <= 1'b0;
        end else if (w_take) begin
            r_cnt <= w_cnt_next;
            if (w_end) begin
                r_res_err <= w_err;
            end
        end
    end
`else
    assign w_end   = digit_last;
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 9'd0;
            r_res   <= 9'd0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_take) begin
                        r_acc <= w_acc_next;
                        if (w_end) begin
                            r_res   <= w_acc_next;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod461_horner_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod461_horner_reducer
// Purpose  : Self-checking bench for mod461_horner_reducer (table + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod461_horner_reducer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] digit;
    logic       digit_valid;
    logic       digit_last;
    logic       digit_ready;
    logic [8:0] res;
    logic       res_valid;
    logic       res_err;
    logic       res_ready;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MOD461_FRAMECHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int n;
        int a;
        int b;
        int exp_res;
        bit exp_err_chk;
    } vec_t;

    mod461_horner_reducer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_last  (digit_last),
        .digit_ready (digit_ready),
        .res         (res),
        .res_valid   (res_valid),
        .res_err     (res_err),
        .res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Operand value mod 461 as sum of d_i * 64^(position), computed LSB-first.
    function automatic int model_mod(input int q[$]);
        longint s = 0;
        longint p = 1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            s = (s + longint'(q[i]) * p) % 461;
            p = (p * 64) % 461;
        end
        return int'(s);
    endfunction

    task automatic drive_digit(input int d, input bit last, input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) begin
            digit_valid = 1'b0;
            digit       = 6'($urandom);
            digit_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        digit       = 6'(d);
        digit_last  = last;
        digit_valid = 1'b1;
        check("digit_ready", int'(digit_ready), 1);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
    endtask

    task automatic send_frame(input int q[$], input int gap_pct);
        for (int i = 0; i < q.size(); i++) begin
            drive_digit(q[i], (i == q.size() - 1), gap_pct);
        end
    endtask

    task automatic expect_result(input string tag, input int exp_res, input int exp_err);
        check({tag, "_valid"}, int'(res_valid), 1);
        check({tag, "_res"}, int'(res), exp_res);
        check({tag, "_err"}, int'(res_err), exp_err);
    endtask

    task automatic collect();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("idle_valid", int'(res_valid), 0);
        check("idle_ready", int'(digit_ready), 1);
    endtask

    initial begin
        vec_t vecs[6];
        int   q[$];
        int   exp_r;

        vecs[0] = '{n: 67, a: 7,  b: 13, exp_res: 0,   exp_err_chk: 1'b0};
        vecs[1] = '{n: 67, a: 63, b: 63, exp_res: 407, exp_err_chk: 1'b0};
        vecs[2] = '{n: 3,  a: 0,  b: 5,  exp_res: 5,   exp_err_chk: 1'b1};
        vecs[3] = '{n: 1,  a: 0,  b: 17, exp_res: 17,  exp_err_chk: 1'b1};
        vecs[4] = '{n: 2,  a: 1,  b: 0,  exp_res: 64,  exp_err_chk: 1'b1};
        vecs[5] = '{n: 67, a: 0,  b: 9,  exp_res: 9,   exp_err_chk: 1'b0};

        rst_n       = 1'b0;
        digit       = 6'd0;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        res_ready   = 1'b0;
        #1;
        check("rst_ready", int'(digit_ready), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_res", int'(res), 0);
        check("rst_err", int'(res_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", int'(digit_ready), 1);

        // Directed frames: zeros followed by a two-digit tail, back-to-back digits.
        foreach (vecs[v]) begin
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) q.push_back(0);
            if (vecs[v].n >= 2) q[vecs[v].n - 2] = vecs[v].a;
            q[vecs[v].n - 1] = vecs[v].b;
            send_frame(q, 0);
            expect_result($sformatf("vec%0d", v), vecs[v].exp_res,
                          CHK ? int'(vecs[v].exp_err_chk) : 0);
            collect();
        end

        // Result stall: result held, stray digits ignored, transfer on sixth cycle.
        q.delete();
        for (int i = 0; i < 65; i++) q.push_back(0);
        q.push_back(63);
        q.push_back(63);
        send_frame(q, 0);
        digit       = 6'd33;
        digit_last  = 1'b1;
        digit_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_valid", int'(res_valid), 1);
            check("stall_res", int'(res), 407);
            check("stall_ready", int'(digit_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready   = 1'b0;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        check("stall_done_valid", int'(res_valid), 0);
        check("stall_done_ready", int'(digit_ready), 1);
        send_frame('{0, 0, 5}, 0);
        expect_result("after_stall", 5, CHK ? 1 : 0);
        collect();

        // Overlong frame: 67 digits without digit_last.
        q.delete();
        for (int i = 0; i < 67; i++) begin
            q.push_back(1);
            drive_digit(1, 1'b0, 0);
        end
        if (CHK) begin
            expect_result("overlong", model_mod(q), 1);
        end else begin
            check("overlong_open", int'(res_valid), 0);
            q.push_back(1);
            drive_digit(1, 1'b1, 0);
            expect_result("overlong", model_mod(q), 0);
        end
        collect();

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 30; i++) drive_digit(int'($urandom_range(63)), 1'b0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(digit_ready), 0);
        check("mid_rst_valid", int'(res_valid), 0);
        check("mid_rst_res", int'(res), 0);
        check("mid_rst_err", int'(res_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel_rst_ready", int'(digit_ready), 0);
        @(posedge clk);
        #1;
        check("rel_rst_ready2", int'(digit_ready), 1);
        q.delete();
        for (int i = 0; i < 66; i++) q.push_back(0);
        q.push_back(9);
        send_frame(q, 0);
        expect_result("after_rst", 9, 0);
        collect();

        // Random full-length frames with random valid gaps.
        for (int f = 0; f < 8; f++) begin
            q.delete();
            for (int i = 0; i < 67; i++) q.push_back(int'($urandom_range(63)));
            exp_r = model_mod(q);
            send_frame(q, 25);
            expect_result($sformatf("rand%0d", f), exp_r, 0);
            collect();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod461_horner_reducer.md
MOD461_HORNER_REDUCER -- requirements
Module: mod461_horner_reducer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: digit  in  6  operand digit, MSB-first, base 64.
REQ-004 SHALL have: digit_valid  in  1  digit/digit_last qualifier.
REQ-005 SHALL have: digit_last  in  1  final digit of operand frame.
REQ-006 SHALL have: digit_ready  out  1  block accepts digit this cycle.
REQ-007 SHALL have: res  out  9  operand mod 461, range 0..460.
REQ-008 SHALL have: res_valid  out  1  res/res_err qualifier.
REQ-009 SHALL have: res_err  out  1  frame length error flag.
REQ-010 SHALL have: res_ready  in  1  downstream accepts result.

Function
REQ-011 Digit transfer SHALL occur on a rising edge with digit_valid=1 and digit_ready=1; result transfer SHALL occur on a rising edge with res_valid=1 and res_ready=1.
REQ-012 SHALL implement FSM IDLE, ACCUM, DONE; reset state IDLE.
REQ-013 IDLE/ACCUM: digit_ready=1, res_valid=0; DONE: digit_ready=0, res_valid=1.
REQ-014 Per accepted digit d: acc_next = (acc*64 + d) mod 461, one digit per cycle, no bubbles; acc SHALL be cleared at frame start (first digit in IDLE uses acc=0).
REQ-015 Intermediate acc*64+d (max 29503, 15 bits) SHALL be fully reduced to 0..460 within the same cycle; acc SHALL never hold a value >=461.
REQ-016 IDLE -> ACCUM on accepted digit with digit_last=0; IDLE/ACCUM -> DONE on accepted digit with digit_last=1 (single-digit frame legal).
REQ-017 Latency: res_valid SHALL rise the cycle after the last-digit transfer, res = final acc.
REQ-018 DONE: res, res_err SHALL hold stable while res_ready=0; DONE -> IDLE on result transfer; next frame's first digit accepted no earlier than the following cycle.
REQ-019 Digit counter (7 bits) SHALL count accepted digits per frame; nominal frame 67 digits (402-bit operand).
REQ-020 digit_valid=0 cycles inside a frame SHALL leave acc and counter unchanged.
REQ-021 digit input while digit_ready=0 SHALL be ignored.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, acc=0, counter=0, res=0, res_valid=0, res_err=0, digit_ready=0 while asserted.
REQ-023 Reset mid-frame or in DONE SHALL discard the partial/pending result; digit_ready=1 from the first clock edge after rst_n deasserts.

Configuration
REQ-024 Macro MOD461_FRAMECHK_EN SHALL enable frame length checking.
REQ-025 Defined: res_err=1 with result if last arrived at count !=67; a 67th digit without digit_last SHALL be treated as last, res_err=1.
REQ-026 Undefined: res_err tied 0, no counter-based termination; frames of any length end only on digit_last (counter may be omitted).

Verification
REQ-027 65 digits 0, then 7, 13(last) -> res=0 (461 mod 461), res_err=0.
REQ-028 65 digits 0, then 63, 63(last) -> res=407, res_err=0, res_valid one cycle after last transfer.
REQ-029 Frame 0,0,5(last) -> res=5; res_err=1 with MOD461_FRAMECHK_EN, 0 without.
REQ-030 Completed result with res_ready=0 for 5 cycles -> res, res_valid stable, digit_ready=0; digit_valid=1 during stall not consumed; transfer on cycle 6 then IDLE.
REQ-031 rst_n pulsed low after 30 digits -> outputs at reset values; fresh 67-digit frame (66 zeros, 9 last) -> res=9.
REQ-032 Random 67-digit frames with random digit_valid gaps vs. big-integer model mod 461 -> exact match.
